window_stream_gen: RTL

Parametrised sliding-window generator for the input-layer datapath. It consumes a raster-order pixel stream (row-major, one pixel per beat) and emits one packed KERNEL×KERNEL window per output beat, with run-time frame size and stride. It sits between the AXI burst reader and the convolution array. It generalises the fixed 3×3, 8-bit, stride-1 window path with a configurable kernel, pixel width, maximum row length, stride 1/2, full valid/ready backpressure, and frame-level error/done reporting.

---
 rtl/window_stream_pkg.sv | 21 ++
 rtl/window_line_buffer.sv | 23 ++
 rtl/window_stream_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/window_stream_pkg.sv
// Shared types and helpers for the sliding-window generator: FSM states,
// window packing offsets and the frame-configuration legality rule.
package window_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int MIN_KERNEL = 2;

  function automatic int packOffset(input int i, input int j, input int kernel, input int width);
    return (i * kernel + j) * width;
  endfunction

  function automatic logic cfgLegal(input int rows, input int cols, input int kernel, input int maxCols);
    return (kernel >= MIN_KERNEL) && (kernel <= rows) && (kernel <= cols) && (cols <= maxCols);
  endfunction

endpackage

// File: rtl/window_line_buffer.sv
// One row of pixel history. The read is asynchronous and the write lands on
// the clock edge, so a same-cycle read at the write address sees the old word.
module window_line_buffer #(
  parameter int PIXEL_WIDTH = 8,
  parameter int MAX_COLS    = 64,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                   i_clk,
  input  logic                   i_we,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic [PIXEL_WIDTH-1:0] i_wdata,
  output logic [PIXEL_WIDTH-1:0] o_rdata
);

  logic [PIXEL_WIDTH-1:0] r_mem [MAX_COLS];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window_stream_gen.sv
// Raster pixel stream in, packed KERNEL x KERNEL windows out, with run-time
// frame size, stride 1/2 and a single registered, backpressured output stage.
module window_stream_gen
  import window_stream_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int KERNEL      = 3,
  parameter int MAX_COLS    = 64,
  parameter int DIM_WIDTH   = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset_n,
  input  logic                                 i_start,
  input  logic [DIM_WIDTH-1:0]                 i_row_size,
  input  logic [DIM_WIDTH-1:0]                 i_col_size,
  input  logic                                 i_stride_2,
  input  logic [PIXEL_WIDTH-1:0]               i_pix_data,
  input  logic                                 i_pix_valid,
  output logic                                 o_pix_rdy,
  output logic [KERNEL*KERNEL*PIXEL_WIDTH-1:0] o_win_data,
  output logic                                 o_win_valid,
  input  logic                                 i_win_rdy,
  output logic                                 o_win_last,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err
);

  localparam int   AW         = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int   WW         = KERNEL * KERNEL * PIXEL_WIDTH;
  localparam logic K_PAR      = 1'(KERNEL % 2);
  localparam logic PHASE_INIT = 1'((KERNEL - 1) % 2);

  state_t r_state, w_nextState;

  logic [DIM_WIDTH-1:0]   r_rows, r_cols, r_lastRow, r_lastCol, r_r, r_c;
  logic                   r_stride2, r_rowPhase, r_colPhase;
  logic [PIXEL_WIDTH-1:0] r_win [KERNEL][KERNEL];
  logic [WW-1:0]          r_winData;
  logic                   r_winValid, r_winLast, r_done, r_err;

  logic                   w_pixRdy, w_accept, w_cfgLoad, w_cfgErr, w_doneSet;
  logic                   w_atEnd, w_emit, w_isLast, w_rowTrim, w_colTrim;
  logic [AW-1:0]          w_addr;
  logic [PIXEL_WIDTH-1:0] w_lbIn  [KERNEL-1];
  logic [PIXEL_WIDTH-1:0] w_lbOut [KERNEL-1];
  logic [PIXEL_WIDTH-1:0] w_newWin [KERNEL][KERNEL];
  logic [WW-1:0]          w_newPacked;

  assign w_addr    = r_c[AW-1:0];
  assign w_atEnd   = (r_r == r_rows - DIM_WIDTH'(1)) && (r_c == r_cols - DIM_WIDTH'(1));
  assign w_isLast  = (r_r == r_lastRow) && (r_c == r_lastCol);
  // With stride 2, an odd (size - KERNEL) leaves one trailing row/column unused.
  assign w_rowTrim = i_stride_2 & (i_row_size[0] ^ K_PAR);
  assign w_colTrim = i_stride_2 & (i_col_size[0] ^ K_PAR);
  assign w_emit    = (r_r >= DIM_WIDTH'(KERNEL - 1)) && (r_c >= DIM_WIDTH'(KERNEL - 1)) &&
                     (!r_stride2 || (!r_rowPhase && !r_colPhase));

  genvar k;
  generate
    for (k = 0; k < KERNEL - 1; k++) begin : g_lb
      if (k == 0) begin : g_head
        assign w_lbIn[k] = i_pix_data;
      end else begin : g_tail
        assign w_lbIn[k] = w_lbOut[k-1];
      end
      window_line_buffer #(
        .PIXEL_WIDTH(PIXEL_WIDTH),
        .MAX_COLS   (MAX_COLS),
        .ADDR_WIDTH (AW)
      ) u_lineBuffer (
        .i_clk  (i_clk),
        .i_we   (w_accept),
        .i_addr (w_addr),
        .i_wdata(w_lbIn[k]),
        .o_rdata(w_lbOut[k])
      );
    end
  endgenerate

  // Shift the window left and load the new column, deepest buffer on top.
  always_comb begin
    for (int i = 0; i < KERNEL; i++) begin
      for (int j = 0; j < KERNEL - 1; j++) w_newWin[i][j] = r_win[i][j+1];
    end
    for (int i = 0; i < KERNEL - 1; i++) w_newWin[i][KERNEL-1] = w_lbOut[KERNEL-2-i];
    w_newWin[KERNEL-1][KERNEL-1] = i_pix_data;
    w_newPacked = '0;
    for (int i = 0; i < KERNEL; i++) begin
      for (int j = 0; j < KERNEL; j++) begin
        w_newPacked[packOffset(i, j, KERNEL, PIXEL_WIDTH) +: PIXEL_WIDTH] = w_newWin[i][j];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_pixRdy    = 1'b0;
    w_accept    = 1'b0;
    w_cfgLoad   = 1'b0;
    w_cfgErr    = 1'b0;
    w_doneSet   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          if (cfgLegal(int'(i_row_size), int'(i_col_size), KERNEL, MAX_COLS)) begin
            w_cfgLoad   = 1'b1;
            w_nextState = RUN;
          end else begin
            w_cfgErr = 1'b1;
          end
        end
      end
      RUN: begin
        w_pixRdy = !r_winValid || i_win_rdy;
        w_accept = i_pix_valid && w_pixRdy;
        if (w_accept && w_atEnd) w_nextState = FLUSH;
      end
      FLUSH: begin
        if (!r_winValid || i_win_rdy) begin
          w_nextState = IDLE;
          w_doneSet   = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_rows     <= '0;
      r_cols     <= '0;
      r_lastRow  <= '0;
      r_lastCol  <= '0;
      r_r        <= '0;
      r_c        <= '0;
      r_stride2  <= 1'b0;
      r_rowPhase <= 1'b0;
      r_colPhase <= 1'b0;
      r_winData  <= '0;
      r_winValid <= 1'b0;
      r_winLast  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      for (int i = 0; i < KERNEL; i++) begin
        for (int j = 0; j < KERNEL; j++) r_win[i][j] <= '0;
      end
    end else begin
      r_done <= w_doneSet;
      r_err  <= w_cfgErr;
      if (w_cfgLoad) begin
        r_rows     <= i_row_size;
        r_cols     <= i_col_size;
        r_stride2  <= i_stride_2;
        r_lastRow  <= i_row_size - DIM_WIDTH'(1) - DIM_WIDTH'(w_rowTrim);
        r_lastCol  <= i_col_size - DIM_WIDTH'(1) - DIM_WIDTH'(w_colTrim);
        r_r        <= '0;
        r_c        <= '0;
        r_rowPhase <= PHASE_INIT;
        r_colPhase <= PHASE_INIT;
      end
      if (w_accept) begin
        r_win <= w_newWin;
        if (r_c == r_cols - DIM_WIDTH'(1)) begin
          r_c        <= '0;
          r_colPhase <= PHASE_INIT;
          r_r        <= r_r + DIM_WIDTH'(1);
          r_rowPhase <= ~r_rowPhase;
        end else begin
          r_c        <= r_c + DIM_WIDTH'(1);
          r_colPhase <= ~r_colPhase;
        end
      end
      if (r_winValid && i_win_rdy) begin
        r_winValid <= 1'b0;
        r_winLast  <= 1'b0;
      end
      if (w_accept && w_emit) begin
        r_winValid <= 1'b1;
        r_winData  <= w_newPacked;
        r_winLast  <= w_isLast;
      end
    end
  end

  assign o_pix_rdy   = w_pixRdy;
  assign o_win_data  = r_winData;
  assign o_win_valid = r_winValid;
  assign o_win_last  = r_winLast;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule
